fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the single-cycle RISC-V core. It owns the architectural program counter and runs a request/acknowledge handshake to instruction memory. It hands each fetched word to decode through a valid/ready interface and applies jump/branch redirects computed in execute. It replaces free-running PC increment with a controller that tolerates multi-cycle memory, decode back-pressure and flushes.

---
 rtl/fetch_ctrl.sv | 132 +++++++++++++
 tb/tb_fetch_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the req/ack handshake to imem,
// buffers one word for decode and applies execute-stage redirects.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_count,
    output logic        misalign_err
);

    typedef enum logic [2:0] {IDLE, FETCH, HOLD, DISCARD, HALT} state_e;

    state_e      state_q, state_d;
    logic        halt_pend_q, halt_pend_d;
    logic        imem_req_q, imem_req_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        misalign_q, misalign_d;

    logic redir_ok, redir_bad, take_word;

    assign redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign take_word = (state_q == FETCH) && imem_ack && !redirect_valid;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= IDLE;
            halt_pend_q   <= 1'b0;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= 32'd0;
            inst_valid_q  <= 1'b0;
            inst_q        <= 32'd0;
            inst_pc_q     <= 32'd0;
            fetch_pc_q    <= RESET_PC;
            fetch_count_q <= 32'd0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            halt_pend_q   <= halt_pend_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            inst_valid_q  <= inst_valid_d;
            inst_q        <= inst_d;
            inst_pc_q     <= inst_pc_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_count_q <= fetch_count_d;
            misalign_q    <= misalign_d;
        end
    end

    // halt_pend remembers a misaligned redirect seen while a request was still open
    always_comb begin
        state_d     = state_q;
        halt_pend_d = halt_pend_q;
        case (state_q)
            IDLE: state_d = redir_bad ? HALT : FETCH;
            FETCH: begin
                if (redir_bad) begin
                    if (imem_ack) begin
                        state_d = HALT;
                    end else begin
                        state_d     = DISCARD;
                        halt_pend_d = 1'b1;
                    end
                end else if (redir_ok) begin
                    state_d = imem_ack ? FETCH : DISCARD;
                end else if (imem_ack) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redir_bad)                    state_d = HALT;
                else if (redir_ok || inst_ready)  state_d = FETCH;
            end
            DISCARD: begin
                if (imem_ack)       state_d = (halt_pend_q || redir_bad) ? HALT : FETCH;
                else if (redir_bad) halt_pend_d = 1'b1;
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // Request/address are derived from the next state so they are registered
    // and stay frozen while DISCARD waits for the abandoned ack.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        if (state_q != HALT && redir_ok) begin
            fetch_pc_d = redirect_pc;
        end else if (take_word) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (take_word) begin
            inst_d    = imem_rdata;
            inst_pc_d = fetch_pc_q;
        end
        inst_valid_d  = (state_d == HOLD);
        imem_req_d    = (state_d == FETCH) || (state_d == DISCARD);
        imem_addr_d   = (state_d == FETCH) ? fetch_pc_d : imem_addr_q;
        fetch_count_d = fetch_count_q + {31'd0, inst_valid_q && inst_ready};
        misalign_d    = misalign_q || (redir_bad && state_q != HALT);
    end

    assign imem_req     = imem_req_q;
    assign imem_addr    = imem_addr_q;
    assign inst_valid   = inst_valid_q;
    assign inst         = inst_q;
    assign inst_pc      = inst_pc_q;
    assign fetch_pc     = fetch_pc_q;
    assign fetch_count  = fetch_count_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized run
// scored against a transaction-level model of the delivered instruction stream.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_count;
    logic        misalign_err;

    logic        w_req, w_ack, w_inst_valid, w_misalign_err;
    logic [31:0] w_addr, w_rdata, w_inst, w_inst_pc, w_fetch_pc, w_fetch_count;

    int checks = 0;
    int errors = 0;
    int lat = 0;
    int wcnt = 0;
    bit mem_rand = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    fetch_ctrl u_dut (
        .clk(clk), .nrst(nrst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .fetch_pc(fetch_pc), .fetch_count(fetch_count), .misalign_err(misalign_err)
    );

    // Second instance with a wrapping reset PC and a zero-wait memory
    assign w_ack   = w_req;
    assign w_rdata = memf(w_addr);

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .nrst(nrst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
        .inst_valid(w_inst_valid), .inst(w_inst), .inst_pc(w_inst_pc), .inst_ready(inst_ready),
        .fetch_pc(w_fetch_pc), .fetch_count(w_fetch_count), .misalign_err(w_misalign_err)
    );

    // Advance one cycle; the memory model decides this cycle's ack, then
    // everything is sampled 1ns after the falling edge.
    task automatic step();
        @(negedge clk);
        if (!imem_req || imem_ack) wcnt = 0;
        if (imem_ack && mem_rand) lat = $urandom_range(0, 3);
        if (imem_req && wcnt >= lat) begin
            imem_ack   = 1'b1;
            imem_rdata = memf(imem_addr);
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            if (imem_req) wcnt++;
        end
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; inst_ready = 1'b0;
        lat = 0; mem_rand = 1'b0;
        repeat (3) step();
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        inst_ready = 1'b1;
        repeat (3) step();
        checks++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL pre_reset_count: got %0d expected 1", fetch_count); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL pre_reset_req: got %b expected 1", imem_req); end
        nrst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", imem_req); end
        checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL rst_addr: got %h expected 0", imem_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", inst_valid); end
        checks++; if (inst !== 32'd0) begin errors++; $display("FAIL rst_inst: got %h expected 0", inst); end
        checks++; if (inst_pc !== 32'd0) begin errors++; $display("FAIL rst_inst_pc: got %h expected 0", inst_pc); end
        checks++; if (fetch_pc !== 32'd0) begin errors++; $display("FAIL rst_fetch_pc: got %h expected 0", fetch_pc); end
        checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", fetch_count); end
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %b expected 0", misalign_err); end
        checks++; if (w_fetch_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL rst_wrap_pc: got %h expected fffffffc", w_fetch_pc); end
        checks++; if ({w_inst, w_fetch_count} !== 64'd0 || w_misalign_err !== 1'b0) begin errors++; $display("FAIL rst_wrap_regs: got %h %h %b expected zeros", w_inst, w_fetch_count, w_misalign_err); end
    endtask

    task automatic test_zero_wait();
        do_reset();
        inst_ready = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            checks++; if (imem_req !== (k % 2 == 1)) begin errors++; $display("FAIL zw_req[%0d]: got %b expected %b", k, imem_req, (k % 2 == 1)); end
            if (k % 2 == 1) begin
                checks++; if (imem_addr !== 32'((k - 1) * 2)) begin errors++; $display("FAIL zw_addr[%0d]: got %h expected %h", k, imem_addr, 32'((k - 1) * 2)); end
            end
            checks++; if (inst_valid !== (k % 2 == 0)) begin errors++; $display("FAIL zw_valid[%0d]: got %b expected %b", k, inst_valid, (k % 2 == 0)); end
            if (k % 2 == 0) begin
                checks++; if (inst_pc !== 32'((k - 2) * 2) || inst !== memf(32'((k - 2) * 2))) begin errors++; $display("FAIL zw_inst[%0d]: got pc %h inst %h expected pc %h", k, inst_pc, inst, 32'((k - 2) * 2)); end
            end
        end
        checks++; if (fetch_count !== 32'd3) begin errors++; $display("FAIL zw_count: got %0d expected 3", fetch_count); end
        inst_ready = 1'b0;
    endtask

    task automatic test_wait_hold();
        do_reset();
        lat = 3;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0 || inst_valid !== 1'b0) begin errors++; $display("FAIL wait_stable[%0d]: got req %b addr %h valid %b expected 1 0 0", k, imem_req, imem_addr, inst_valid); end
        end
        for (int k = 5; k <= 9; k++) begin
            step();
            checks++; if (inst_valid !== 1'b1 || inst !== memf(32'd0) || inst_pc !== 32'd0) begin errors++; $display("FAIL hold_inst[%0d]: got valid %b inst %h pc %h expected 1 %h 0", k, inst_valid, inst, inst_pc, memf(32'd0)); end
            checks++; if (imem_req !== 1'b0 || fetch_count !== 32'd0 || fetch_pc !== 32'd4) begin errors++; $display("FAIL hold_state[%0d]: got req %b count %0d fpc %h expected 0 0 4", k, imem_req, fetch_count, fetch_pc); end
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd4) begin errors++; $display("FAIL hold_next_req: got req %b addr %h expected 1 4", imem_req, imem_addr); end
        checks++; if (fetch_count !== 32'd1 || inst_valid !== 1'b0) begin errors++; $display("FAIL hold_release: got count %0d valid %b expected 1 0", fetch_count, inst_valid); end
    endtask

    task automatic test_redirect_discard();
        bit found, acked, bad_hold, got_inst, got_new;
        logic [31:0] new_addr, first_pc, first_inst;
        found = 0; acked = 0; bad_hold = 0; got_inst = 0; got_new = 0;
        new_addr = 32'd0; first_pc = 32'd0; first_inst = 32'd0;
        do_reset();
        lat = 3;
        inst_ready = 1'b1;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (imem_req && imem_addr == 32'd8 && !imem_ack) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL rd_reach_8: got no pending req at 8 expected one within 60 cycles"); end
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        checks++; if (fetch_pc !== 32'h100) begin errors++; $display("FAIL rd_fetch_pc: got %h expected 100", fetch_pc); end
        if (imem_ack) acked = 1;
        if (!imem_req || imem_addr !== 32'd8) bad_hold = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (inst_valid && !got_inst) begin got_inst = 1; first_pc = inst_pc; first_inst = inst; end
            if (!acked) begin
                if (!imem_req || imem_addr !== 32'd8) bad_hold = 1;
                if (imem_ack) acked = 1;
            end else if (!got_new && imem_req) begin
                got_new = 1; new_addr = imem_addr;
            end
        end
        checks++; if (bad_hold || !acked) begin errors++; $display("FAIL rd_hold_old: got hold_broken %b acked %b expected 0 1", bad_hold, acked); end
        checks++; if (!got_new || new_addr !== 32'h100) begin errors++; $display("FAIL rd_new_req: got seen %b addr %h expected 1 100", got_new, new_addr); end
        checks++; if (!got_inst || first_pc !== 32'h100 || first_inst !== memf(32'h100)) begin errors++; $display("FAIL rd_first_inst: got seen %b pc %h inst %h expected 1 100 %h", got_inst, first_pc, first_inst, memf(32'h100)); end
        inst_ready = 1'b0;
    endtask

    task automatic test_misalign();
        bit found;
        found = 0;
        do_reset();
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (inst_valid) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL ma_reach_hold: got no inst_valid expected one within 20 cycles"); end
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        step();
        redirect_valid = 1'b0;
        checks++; if (misalign_err !== 1'b1 || inst_valid !== 1'b0 || fetch_pc !== 32'd4) begin errors++; $display("FAIL ma_set: got err %b valid %b fpc %h expected 1 0 4", misalign_err, inst_valid, fetch_pc); end
        for (int i = 0; i < 10; i++) begin
            inst_ready = 1'($urandom);
            redirect_valid = 1'($urandom);
            redirect_pc = $urandom & 32'hFFFF_FFFC;
            step();
            checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0 || misalign_err !== 1'b1 || fetch_pc !== 32'd4) begin errors++; $display("FAIL ma_halt[%0d]: got req %b valid %b err %b fpc %h expected 0 0 1 4", i, imem_req, inst_valid, misalign_err, fetch_pc); end
        end
        redirect_valid = 1'b0; inst_ready = 1'b0;
        nrst = 1'b0;
        #1;
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL ma_clear: got %b expected 0", misalign_err); end
    endtask

    task automatic test_wrap();
        do_reset();
        inst_ready = 1'b1;
        step();
        checks++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req0: got req %b addr %h expected 1 fffffffc", w_req, w_addr); end
        step();
        checks++; if (w_inst_valid !== 1'b1 || w_inst_pc !== 32'hFFFF_FFFC || w_fetch_pc !== 32'd0) begin errors++; $display("FAIL wrap_pc: got valid %b pc %h fpc %h expected 1 fffffffc 0", w_inst_valid, w_inst_pc, w_fetch_pc); end
        step();
        checks++; if (w_req !== 1'b1 || w_addr !== 32'd0) begin errors++; $display("FAIL wrap_req1: got req %b addr %h expected 1 0", w_req, w_addr); end
        inst_ready = 1'b0;
    endtask

    // Model: delivered instructions form the sequence start, start+4, ... where
    // start is the reset PC or the latest redirect target; data is memf(pc).
    task automatic test_random();
        logic [31:0] exp_pc, exp_cnt, paddr;
        logic        preq, pack;
        exp_pc = 32'd0; exp_cnt = 32'd0; paddr = 32'd0; preq = 1'b0; pack = 1'b0;
        do_reset();
        mem_rand = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (preq && !pack) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== paddr) begin errors++; $display("FAIL rnd_req_stable[%0d]: got req %b addr %h expected 1 %h", c, imem_req, imem_addr, paddr); end
            end
            checks++; if (fetch_count !== exp_cnt) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", c, fetch_count, exp_cnt); end
            inst_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom & 32'h0000_0FFC;
            if (inst_valid && inst_ready) begin
                checks++; if (inst_pc !== exp_pc || inst !== memf(exp_pc)) begin errors++; $display("FAIL rnd_inst[%0d]: got pc %h inst %h expected pc %h inst %h", c, inst_pc, inst, exp_pc, memf(exp_pc)); end
                exp_pc = exp_pc + 32'd4;
                exp_cnt = exp_cnt + 32'd1;
            end
            if (redirect_valid) exp_pc = redirect_pc;
            preq = imem_req; pack = imem_ack; paddr = imem_addr;
        end
        redirect_valid = 1'b0; inst_ready = 1'b0; mem_rand = 1'b0; lat = 0;
        checks++; if (exp_cnt < 32'd100 || misalign_err !== 1'b0) begin errors++; $display("FAIL rnd_progress: got transfers %0d err %b expected >=100 0", exp_cnt, misalign_err); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_hold();
        test_redirect_discard();
        test_misalign();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
